obs_move_ctrl: RTL
==================

# obs_move_ctrl

Sequencing controller for one bouncing obstacle sprite (2 px wide × 16 px tall). It owns the sprite's position and direction and generates the frame/move timebase. On each move tick it drives the shared VGA plot port through an erase-old, step, draw-new pass. It sits between the obstacle spawn logic (which supplies the start column) and the VGA adapter's x/y/colour/plot inputs.

## Interface
- CLK_PER_FRAME, 833334: clock cycles per 1/60 s frame at 50 MHz.
- FRAMES_PER_MOVE, 10: frames between position steps.
- Y_MAX, 104: lowest allowed top-row y; reaching it reverses direction.
- OBS_COLOUR, 3'd1: draw colour (erase colour is always 3'd0).
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  advances the frame timebase; low freezes it.
- load  in  1  one-cycle pulse: spawn a sprite at column load_x, row 0.
- load_x  in  8  spawn column (spawn logic supplies {3'b010, lfsr[4:0]}).
- x  out  8  plot column.
- y  out  7  plot row.
- colour  out  3  plot colour.
- plot  out  1  VGA write strobe.
- busy  out  1  high in DRAW, ERASE, STEP.
- move_tick  out  1  one-cycle pulse when a move is due.

## Operation
- States: IDLE, DRAW, WAIT, ERASE, STEP.
- IDLE:
  - plot=0.
  - load=1 → pos_x←load_x, pos_y←0, dir←down, p←0, go to DRAW.
  - load is ignored in every other state.
- DRAW: 32 cycles.
  - plot=1, colour=OBS_COLOUR, x=pos_x+p[4], y=pos_y+p[3:0].
  - p increments each cycle; p==31 → WAIT, p←0.
- WAIT:
  - plot=0.
  - If move_pend → clear it and go to ERASE.
- ERASE: identical to DRAW with colour=3'd0 and the same pos; p==31 → STEP.
- STEP: one cycle, plot=0.
  - Down: pos_y==Y_MAX → dir←up, pos_y←pos_y−1; else pos_y←pos_y+1.
  - Up: pos_y==0 → dir←down, pos_y←pos_y+1; else pos_y←pos_y−1.
  - Then go to DRAW.
  - pos_y stays in 0..Y_MAX. Y_MAX+15 ≤ 119 keeps the sprite on screen.
- Timebase, free-running whenever enable=1 (any state):
  - div counts 0..CLK_PER_FRAME−1.
  - On wrap, frm counts 0..FRAMES_PER_MOVE−1.
  - On frm wrap, move_tick=1 for that cycle and move_pend←1.
- move_pend stays set until consumed in WAIT. A tick arriving during DRAW/ERASE/STEP is serviced on WAIT entry. Multiple ticks collapse into one.
- x addition is 8-bit wrapping and y addition is 7-bit wrapping; no saturation.
- Reset (any state, including mid-pass) takes effect at the next edge:
  - state=IDLE, pos_x=0, pos_y=0, dir=down, p=0, div=0, frm=0, move_pend=0.
  - Outputs: plot=0, busy=0, move_tick=0, colour=0, x=0, y=0.
  - A partially drawn sprite is not erased.

## Timing
- All outputs decode from registers only; there is no input-to-output combinational path.
- load sampled at edge n → plot=1 with p=0 at cycle n+1. The initial draw spans cycles n+1..n+32.
- Entering ERASE (first cycle after WAIT sees move_pend) to returning to WAIT takes 65 cycles: 32 erase, 1 step, 32 draw.
- WAIT → ERASE takes one cycle after move_pend is visible, so ERASE starts 1 cycle after move_tick when the tick falls in WAIT.
- busy=1 exactly while state ∈ {DRAW, ERASE, STEP}.

## Structure
- Package obs_pkg holds:
  - state enum;
  - SPRITE_W=2, SPRITE_H=16, PIX_PER_SPRITE=32;
  - COL_ERASE=3'd0;
  - default Y_MAX.
- Sub-module frame_tick_gen (div + frm counters, outputs move_tick) is split out; the FSM, position registers and pixel counter stay in obs_move_ctrl.

## Test plan
All scenarios use CLK_PER_FRAME=4, FRAMES_PER_MOVE=2, Y_MAX=3.
- Reset, then load with load_x=8'h45 → 32 plots, colour=1. (x,y) runs (0x45,0..15) then (0x46,0..15). busy falls after cycle 32.
- First move → 32 erase plots at y 0..15 with colour 0, one STEP cycle, then draws at y 1..16. move_tick period = 8 cycles.
- Bounce: pos_y runs 0,1,2,3,2,1,0,1 across successive moves. Direction flips exactly at 3 and at 0.
- enable=0 held for 20 cycles in WAIT → no move_tick, no plot. Resume → tick arrives at the remaining count, not restarted.
- load asserted mid-DRAW and in WAIT → ignored; pos_x is unchanged.
- reset asserted at p=10 of ERASE → next cycle plot=0, state IDLE, all outputs 0. A following load draws at row 0.

Source files
------------

// File: rtl/obs_pkg.sv
// -----------------------------------------------------------------------------
// obs_pkg
// Shared types and constants for the bouncing-obstacle sprite controller.
//   state_t        : sequencing states of obs_move_ctrl
//   dir_t          : vertical travel direction
//   sprite geometry: SPRITE_W x SPRITE_H pixels, PIX_PER_SPRITE plots per pass
//   COL_ERASE      : colour written when removing the sprite
//   Y_MAX_DEFAULT  : default lowest top-row position before bouncing
// -----------------------------------------------------------------------------
package obs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ERASE = 3'd3,
        ST_STEP  = 3'd4
    } state_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int SPRITE_W       = 2;
    localparam int SPRITE_H       = 16;
    localparam int PIX_PER_SPRITE = SPRITE_W * SPRITE_H;

    // Pixel counter layout: low ROW_W bits select the row, the top bit the column.
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam int P_W   = $clog2(PIX_PER_SPRITE);

    localparam logic [2:0] COL_ERASE     = 3'd0;
    localparam int         Y_MAX_DEFAULT = 104;

endpackage

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Free-running frame/move timebase. A clock divider counts CLK_PER_FRAME
// cycles per frame; a frame counter counts FRAMES_PER_MOVE frames per move.
// Both advance only while enable is high.
//   clock     in  : system clock
//   reset     in  : synchronous, active-high reset
//   enable    in  : advances the timebase; low freezes both counters
//   move_tick out : registered one-cycle pulse, the cycle after the frame
//                   counter wraps
// -----------------------------------------------------------------------------
module frame_tick_gen #(
    parameter int CLK_PER_FRAME   = 833334,
    parameter int FRAMES_PER_MOVE = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic move_tick
);

    localparam int DIV_W = (CLK_PER_FRAME   > 1) ? $clog2(CLK_PER_FRAME)   : 1;
    localparam int FRM_W = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_FRAME - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_MOVE - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic             tick_q, tick_d;

    always_comb begin
        div_d  = div_q;
        frm_d  = frm_q;
        tick_d = 1'b0;
        if (enable) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (frm_q == FRM_LAST) begin
                    frm_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    frm_d = frm_q + FRM_W'(1);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q  <= '0;
            frm_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            frm_q  <= frm_d;
            tick_q <= tick_d;
        end
    end

    // Registered so move_tick has no combinational path from enable.
    assign move_tick = tick_q;

endmodule

// File: rtl/obs_move_ctrl.sv
// -----------------------------------------------------------------------------
// obs_move_ctrl
// Sequencer for one bouncing 2x16 obstacle sprite. Owns position/direction,
// and on each move drives the VGA plot port through erase-old, step,
// draw-new passes.
//   clock     in  : system clock
//   reset     in  : synchronous, active-high reset
//   enable    in  : advances the frame timebase
//   load      in  : one-cycle spawn pulse (honoured only when idle)
//   load_x    in  : spawn column
//   x, y      out : plot coordinates
//   colour    out : plot colour (OBS_COLOUR when drawing, 0 when erasing)
//   plot      out : VGA write strobe
//   busy      out : high during DRAW, ERASE and STEP
//   move_tick out : one-cycle pulse when a move becomes due
// -----------------------------------------------------------------------------
module obs_move_ctrl
    import obs_pkg::*;
#(
    parameter int         CLK_PER_FRAME   = 833334,
    parameter int         FRAMES_PER_MOVE = 10,
    parameter int         Y_MAX           = Y_MAX_DEFAULT,
    parameter logic [2:0] OBS_COLOUR      = 3'd1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] load_x,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       move_tick
);

    localparam logic [P_W-1:0] PIX_LAST = P_W'(PIX_PER_SPRITE - 1);
    localparam logic [6:0]     Y_LAST   = 7'(Y_MAX);

    state_t         state_q, state_d;
    logic [7:0]     pos_x_q, pos_x_d;
    logic [6:0]     pos_y_q, pos_y_d;
    dir_t           dir_q, dir_d;
    logic [P_W-1:0] p_q, p_d;
    logic           move_pend_q, move_pend_d;
    logic           plotting;

    frame_tick_gen #(
        .CLK_PER_FRAME   (CLK_PER_FRAME),
        .FRAMES_PER_MOVE (FRAMES_PER_MOVE)
    ) u_tick (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .move_tick (move_tick)
    );

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_d     = dir_q;
        p_d       = p_q;
        // A tick is folded in immediately so WAIT can react in the same cycle
        // the tick is visible; repeated ticks simply keep the flag set.
        move_pend_d = move_pend_q | move_tick;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    pos_x_d = load_x;
                    pos_y_d = '0;
                    dir_d   = DIR_DOWN;
                    p_d     = '0;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                p_d = p_q + P_W'(1);          // wraps to 0 after the last pixel
                if (p_q == PIX_LAST) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (move_pend_d) begin
                    move_pend_d = 1'b0;
                    state_d     = ST_ERASE;
                end
            end
            ST_ERASE: begin
                p_d = p_q + P_W'(1);
                if (p_q == PIX_LAST) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                state_d = ST_DRAW;
                if (dir_q == DIR_DOWN) begin
                    if (pos_y_q == Y_LAST) begin
                        dir_d   = DIR_UP;
                        pos_y_d = pos_y_q - 7'd1;
                    end else begin
                        pos_y_d = pos_y_q + 7'd1;
                    end
                end else begin
                    if (pos_y_q == 7'd0) begin
                        dir_d   = DIR_DOWN;
                        pos_y_d = pos_y_q + 7'd1;
                    end else begin
                        pos_y_d = pos_y_q - 7'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            dir_q       <= DIR_DOWN;
            p_q         <= '0;
            move_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_q       <= dir_d;
            p_q         <= p_d;
            move_pend_q <= move_pend_d;
        end
    end

    // Outputs decode from registered state only; coordinates are forced to 0
    // whenever no pixel is being written.
    always_comb begin
        plotting = (state_q == ST_DRAW) || (state_q == ST_ERASE);
        plot     = plotting;
        busy     = plotting || (state_q == ST_STEP);
        x        = plotting ? (pos_x_q + 8'(p_q[P_W-1]))      : 8'd0;
        y        = plotting ? (pos_y_q + 7'(p_q[ROW_W-1:0])) : 7'd0;
        colour   = (state_q == ST_DRAW) ? OBS_COLOUR : COL_ERASE;
    end

endmodule
